// File: rtl/cordic_polar_rot.sv
// ============================================================================
// cordic_polar_rot
// ----------------------------------------------------------------------------
// Iterative rotation-mode CORDIC. It takes one polar sample (magnitude, phase)
// and converts it to cartesian (x, y), one micro-rotation per clock. Only one
// sample is in flight at a time. The result is held under backpressure.
//
// Stream format (shared with the vectoring CORDIC, so the two can be chained
// back-to-back for loopback):
//   s_axis_polar_tdata : [DATA_W-1:0]        magnitude, unsigned
//                        [2*DATA_W-1:DATA_W] phase, signed, 1 LSB = pi/2^(DATA_W-1)
//   m_axis_dout_tdata  : [DATA_W-1:0]        x, signed
//                        [2*DATA_W-1:DATA_W] y, signed
//
// Ports:
//   aclk                 clock, rising edge
//   aresetn              asynchronous active-low reset, synchronous release
//   s_axis_polar_tvalid  input sample valid
//   s_axis_polar_tready  block can accept a sample (IDLE only)
//   s_axis_polar_tdata   {phase, magnitude}
//   m_axis_dout_tvalid   result valid
//   m_axis_dout_tready   downstream accepts the result
//   m_axis_dout_tdata    {y, x}
//
// Build option:
//   CORDIC_POLAR_ROT_ROUND_EN  when defined, the guard bits are rounded half up
//                              before saturation; otherwise they are truncated
//                              toward -inf. Timing is identical in both builds.
// ============================================================================
module cordic_polar_rot #(
    parameter int DATA_W     = 8,
    parameter int GUARD      = 4,
    parameter int ITERATIONS = 10
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  s_axis_polar_tvalid,
    output logic                  s_axis_polar_tready,
    input  logic [2*DATA_W-1:0]   s_axis_polar_tdata,
    output logic                  m_axis_dout_tvalid,
    input  logic                  m_axis_dout_tready,
    output logic [2*DATA_W-1:0]   m_axis_dout_tdata
);

    localparam int XW = DATA_W + GUARD + 2;
    localparam int XE = XW + 1;
    localparam int PW = DATA_W + 16;
    localparam int CW = 4;

    localparam logic [CW-1:0]        LAST_ITER = CW'(ITERATIONS - 1);
    localparam logic [PW-1:0]        K_GAIN    = PW'(39797);
    localparam logic signed [XE-1:0] SAT_MAX   = XE'((2 ** (DATA_W - 1)) - 1);
    localparam logic signed [XE-1:0] SAT_MIN   = XE'(-(2 ** (DATA_W - 1)));

`ifdef CORDIC_POLAR_ROT_ROUND_EN
    localparam logic signed [XE-1:0] ROUND_BIAS = XE'(2 ** (GUARD - 1));
`else
    localparam logic signed [XE-1:0] ROUND_BIAS = '0;
`endif

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ROTATE = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Arctangent table, atan(2^-i) as a 16-bit binary angle (65536 = 360 deg).
    function automatic logic signed [15:0] atanLut(input logic [CW-1:0] idx);
        logic signed [15:0] a;
        a = '0;
        case (idx)
            4'd0:    a = 16'sd8192;
            4'd1:    a = 16'sd4836;
            4'd2:    a = 16'sd2555;
            4'd3:    a = 16'sd1297;
            4'd4:    a = 16'sd651;
            4'd5:    a = 16'sd326;
            4'd6:    a = 16'sd163;
            4'd7:    a = 16'sd81;
            4'd8:    a = 16'sd41;
            4'd9:    a = 16'sd20;
            4'd10:   a = 16'sd10;
            4'd11:   a = 16'sd5;
            default: a = 16'sd0;
        endcase
        return a;
    endfunction

    // Drop the guard bits (optionally rounding first) and clamp to the
    // signed output range. One extra bit keeps the rounding add from wrapping.
    function automatic logic [DATA_W-1:0] satField(input logic signed [XW-1:0] v);
        logic signed [XE-1:0] biased;
        logic signed [XE-1:0] shifted;
        logic [DATA_W-1:0]    res;
        biased  = {v[XW-1], v} + ROUND_BIAS;
        shifted = biased >>> GUARD;
        if (shifted > SAT_MAX) begin
            res = SAT_MAX[DATA_W-1:0];
        end else if (shifted < SAT_MIN) begin
            res = SAT_MIN[DATA_W-1:0];
        end else begin
            res = DATA_W'(shifted);
        end
        return res;
    endfunction

    state_t                 r_state;
    logic                   r_sReady;
    logic                   r_mValid;
    logic [2*DATA_W-1:0]    r_mData;
    logic [CW-1:0]          r_iter;
    logic signed [XW-1:0]   r_x;
    logic signed [XW-1:0]   r_y;
    logic signed [15:0]     r_z;

    logic [DATA_W-1:0]      w_mag;
    logic [DATA_W-1:0]      w_phase;
    logic [PW-1:0]          w_prod;
    logic signed [XW-1:0]   w_xMag;
    logic signed [XW-1:0]   w_x0;
    logic                   w_fold;
    logic [15:0]            w_zRaw;
    logic [15:0]            w_z0;
    logic signed [XW-1:0]   w_xShift;
    logic signed [XW-1:0]   w_yShift;
    logic signed [XW-1:0]   w_xNext;
    logic signed [XW-1:0]   w_yNext;
    logic signed [15:0]     w_atan;
    logic signed [15:0]     w_zNext;

    // Load path: the magnitude is pre-scaled by the CORDIC gain K (Q0.16) and
    // lands in the x register with GUARD fractional bits.
    assign w_mag   = s_axis_polar_tdata[DATA_W-1:0];
    assign w_phase = s_axis_polar_tdata[2*DATA_W-1:DATA_W];
    assign w_prod  = PW'(w_mag) * K_GAIN;
    assign w_xMag  = XW'(w_prod >> (16 - GUARD));

    // Angles at or beyond +/-90 deg are outside CORDIC convergence, so they
    // are folded by 180 deg: negate x and add half a turn to the angle.
    assign w_fold  = w_phase[DATA_W-1] ^ w_phase[DATA_W-2];
    assign w_zRaw  = 16'(w_phase) << (16 - DATA_W);
    assign w_x0    = w_fold ? -w_xMag : w_xMag;
    assign w_z0    = w_fold ? (w_zRaw + 16'h8000) : w_zRaw;

    // One micro-rotation; the sign of the residual angle picks the direction.
    assign w_xShift = r_x >>> r_iter;
    assign w_yShift = r_y >>> r_iter;
    assign w_atan   = atanLut(r_iter);
    assign w_xNext  = r_z[15] ? (r_x + w_yShift) : (r_x - w_yShift);
    assign w_yNext  = r_z[15] ? (r_y - w_xShift) : (r_y + w_xShift);
    assign w_zNext  = r_z[15] ? (r_z + w_atan)   : (r_z - w_atan);

    assign s_axis_polar_tready = r_sReady;
    assign m_axis_dout_tvalid  = r_mValid;
    assign m_axis_dout_tdata   = r_mData;

    // Control and datapath state machine. tready comes out of a register so it
    // stays low during reset and rises on the first edge after release. The
    // last micro-rotation writes the saturated result directly, so tvalid
    // rises on the same edge that enters DONE.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state  <= IDLE;
            r_sReady <= 1'b0;
            r_mValid <= 1'b0;
            r_mData  <= '0;
            r_iter   <= '0;
            r_x      <= '0;
            r_y      <= '0;
            r_z      <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_sReady <= 1'b1;
                    if (s_axis_polar_tvalid && r_sReady) begin
                        r_x      <= w_x0;
                        r_y      <= '0;
                        r_z      <= w_z0;
                        r_iter   <= '0;
                        r_sReady <= 1'b0;
                        r_state  <= ROTATE;
                    end
                end
                ROTATE: begin
                    r_x <= w_xNext;
                    r_y <= w_yNext;
                    r_z <= w_zNext;
                    if (r_iter == LAST_ITER) begin
                        r_iter   <= '0;
                        r_mValid <= 1'b1;
                        r_mData  <= {satField(w_yNext), satField(w_xNext)};
                        r_state  <= DONE;
                    end else begin
                        r_iter <= r_iter + 4'd1;
                    end
                end
                DONE: begin
                    if (m_axis_dout_tready) begin
                        r_mValid <= 1'b0;
                        r_sReady <= 1'b1;
                        r_state  <= IDLE;
                    end
                end
                default: begin
                    r_state  <= IDLE;
                    r_sReady <= 1'b0;
                    r_mValid <= 1'b0;
                end
            endcase
        end
    end

endmodule
